operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Upstream feeder for the ALU. Accepts decoded operations over a valid/ready handshake and reads both sources from an internal 32-entry register file.
- Applies writeback bypass and a busy-bit scoreboard to resolve RAW and WAW hazards.
- Presents registered A, B and ALUop to the ALU stage through a one-entry output register with valid/ready.
- Writeback from the downstream stage returns through a dedicated write port.

Parameters:
- DATA_WIDTH, 32, operand/register width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_rs  in  ADDR_WIDTH  source register for A
- in_rt  in  ADDR_WIDTH  source register for B
- in_rd  in  ADDR_WIDTH  destination register
- in_wen  in  1  operation will write in_rd
- in_use_imm  in  1  B taken from in_imm, rt ignored
- in_imm  in  DATA_WIDTH  immediate (already extended)
- in_aluop  in  3  ALU opcode (AND 000, OR 001, ADD 010, SUB 110, SLT 111)
- out_valid  out  1  operand bundle valid to ALU
- out_ready  in  1  ALU stage accepts bundle
- out_A  out  DATA_WIDTH  operand A
- out_B  out  DATA_WIDTH  operand B
- out_aluop  out  3  registered opcode
- out_rd  out  ADDR_WIDTH  registered destination
- out_wen  out  1  registered write enable
- wb_en  in  1  writeback strobe
- wb_addr  in  ADDR_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback value
- stall_count  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset, asynchronous on resetn low:
  - All registers and busy bits clear to 0.
  - out_valid, out_A, out_B, out_aluop, out_rd, out_wen and stall_count all go to 0.
  - Any operation in flight is dropped.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy.
- Writeback:
  - When wb_en && wb_addr != 0, the register is written at the clock edge and busy[wb_addr] clears.
  - A writeback to a non-busy register is still written.
- Bypass:
  - A source equal to a nonzero wb_addr while wb_en is high takes wb_data in the same cycle.
  - That source is treated as not busy.
- Hazard, combinational:
  - hz_rs = busy[rs] && !byp_rs
  - hz_rt = !use_imm && busy[rt] && !byp_rt
  - hz_rd = in_wen && busy[rd], with no bypass for this term
  - hazard = hz_rs | hz_rt | hz_rd
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready must not depend on in_valid except through the hazard terms.
- Accept (in_valid && in_ready):
  - Output registers load A, B (imm when use_imm), aluop, rd and wen.
  - out_valid is 1 on the next cycle, giving 1-cycle latency.
  - busy[rd] is set when in_wen && rd != 0. If a writeback clears the same bit in the same cycle, the set wins.
- Drain:
  - out_valid && out_ready with no accept drops out_valid to 0.
  - Output contents are held stable while out_valid && !out_ready.
- Throughput: one operation per cycle when there is no hazard and out_ready is held high.
- Stall counter: increments on each cycle with in_valid && hazard, and saturates at 0xFFFFFFFF.
- Simultaneous accept and drain in the same cycle: the new bundle replaces the old one and out_valid stays 1.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH and the ALUOP_* opcode constants. The same constants are used by the ALU stage.
- Sub-module reg_file: 2 asynchronous read ports, 1 synchronous write port, register 0 hardwired to zero, asynchronous active-low clear, no bypass.
- Bypass, scoreboard, handshake and counter stay in operand_fetch.

Test Plan:
1. Reset, then write r5=0x12345678 via the wb port. Issue rs=5, rt=0, aluop=010, out_ready=1 → one cycle later out_valid=1, out_A=0x12345678, out_B=0.
2. Issue a wen op with rd=3, then the next op reads rs=3 with no writeback → in_ready=0. stall_count increments each cycle. Drive wb_en, wb_addr=3, wb_data=7 → accepted that cycle with out_A=7 (bypass).
3. Hold out_ready=0 with out_valid=1 and present a new op → in_ready=0 and out_* are unchanged. Raise out_ready → the new op loads on the next edge.
4. Issue use_imm=1, in_imm=0xFFFFFFF0, rt=busy register → no stall, out_B=0xFFFFFFF0. Write r0 via wb, then read r0 → out_A=0.
5. Issue a wen op with rd=4, then a second wen op with rd=4 → WAW stall until wb clears r4. Assert resetn=0 mid-stall → out_valid, busy and stall_count are 0 immediately.
6. Drive 256 back-to-back hazard-free ops with out_ready=1 → 256 outputs in order with no bubbles.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared constants for the operand-fetch stage and the ALU stage behind it:
// default datapath/register-index widths and the 3-bit ALU opcode encodings.
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [2:0] aluop_t;

    localparam aluop_t ALUOP_AND = 3'b000;
    localparam aluop_t ALUOP_OR  = 3'b001;
    localparam aluop_t ALUOP_ADD = 3'b010;
    localparam aluop_t ALUOP_SUB = 3'b110;
    localparam aluop_t ALUOP_SLT = 3'b111;

endpackage : operand_fetch_pkg

// File: rtl/operand_fetch_reg_file.sv
// -----------------------------------------------------------------------------
// operand_fetch_reg_file
// 2**ADDR_WIDTH x DATA_WIDTH register file: two asynchronous read ports, one
// synchronous write port, register 0 hardwired to zero. No write-to-read
// bypass here; the caller handles forwarding.
// Ports:
//   clk, resetn        clock / asynchronous active-low clear of every register
//   ra_addr, ra_data   read port A
//   rb_addr, rb_data   read port B
//   we, waddr, wdata   write port (writes to register 0 are discarded)
// -----------------------------------------------------------------------------
module operand_fetch_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    output logic [DATA_WIDTH-1:0] ra_data,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // Flattened view of all registers used by the read muxes.
    logic [NREG-1:0][DATA_WIDTH-1:0] rd_vec;

    assign rd_vec[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] val_q;
            logic [DATA_WIDTH-1:0] val_d;

            always_comb begin
                val_d = val_q;
                if (we && (waddr == ADDR_WIDTH'(gi))) begin
                    val_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    val_q <= '0;
                end else begin
                    val_q <= val_d;
                end
            end

            assign rd_vec[gi] = val_q;
        end
    endgenerate

    assign ra_data = rd_vec[ra_addr];
    assign rb_data = rd_vec[rb_addr];

endmodule : operand_fetch_reg_file

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Feeds the ALU stage. Accepts decoded ops on a valid/ready handshake, reads
// both sources from the internal register file (with same-cycle forwarding
// from the writeback port), stalls on RAW/WAW hazards tracked by busy bits,
// and presents A/B/aluop/rd/wen through a one-entry output register.
// Ports:
//   clk, resetn                   clock / asynchronous active-low reset
//   in_valid/in_ready + in_*      upstream operation
//   out_valid/out_ready + out_*   operand bundle to the ALU
//   wb_en, wb_addr, wb_data       writeback from the downstream stage
//   stall_count                   saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_WIDTH = operand_fetch_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_use_imm,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [2:0]            in_aluop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_A,
    output logic [DATA_WIDTH-1:0] out_B,
    output logic [2:0]            out_aluop,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_wen,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [31:0]           stall_count
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_a;
    logic [DATA_WIDTH-1:0] rf_b;
    logic                  wb_live;

    // Writes to r0 are meaningless, so they neither write nor forward.
    assign wb_live = wb_en && (wb_addr != '0);

    operand_fetch_reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .clk     (clk),
        .resetn  (resetn),
        .ra_addr (in_rs),
        .ra_data (rf_a),
        .rb_addr (in_rt),
        .rb_data (rf_b),
        .we      (wb_live),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
    logic [2:0]            out_aluop_q, out_aluop_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                  out_wen_q, out_wen_d;
    logic [31:0]           stall_q, stall_d;

    logic                  byp_rs, byp_rt;
    logic                  hz_rs, hz_rt, hz_rd, hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] src_a, src_b;

    always_comb begin
        byp_rs = wb_live && (wb_addr == in_rs);
        byp_rt = wb_live && (wb_addr == in_rt);

        hz_rs  = busy_q[in_rs] && !byp_rs;
        hz_rt  = !in_use_imm && busy_q[in_rt] && !byp_rt;
        // The destination check has no forwarding: a pending write to rd
        // must retire before a younger writer of rd may issue.
        hz_rd  = in_wen && busy_q[in_rd];
        hazard = hz_rs || hz_rt || hz_rd;

        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;

        src_a = byp_rs ? wb_data : rf_a;
        if (in_use_imm) begin
            src_b = in_imm;
        end else if (byp_rt) begin
            src_b = wb_data;
        end else begin
            src_b = rf_b;
        end
    end

    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_aluop_d = out_aluop_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        stall_d     = stall_q;

        if (wb_live) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set of the same bit wins.
        if (accept && in_wen && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = src_a;
            out_b_d     = src_b;
            out_aluop_d = in_aluop;
            out_rd_d    = in_rd;
            out_wen_d   = in_wen;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_valid && hazard && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_aluop_q <= '0;
            out_rd_q    <= '0;
            out_wen_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_aluop_q <= out_aluop_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_A       = out_a_q;
    assign out_B       = out_b_q;
    assign out_aluop   = out_aluop_q;
    assign out_rd      = out_rd_q;
    assign out_wen     = out_wen_q;
    assign stall_count = stall_q;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch: a table of single-op vectors followed by
// hand-written sequences for stalls, backpressure, immediates, reset and a
// long back-to-back stream.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic          in_wen, in_use_imm;
    logic [DW-1:0] in_imm;
    logic [2:0]    in_aluop;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_A, out_B;
    logic [2:0]    out_aluop;
    logic [AW-1:0] out_rd;
    logic          out_wen;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [31:0]   stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .in_aluop    (in_aluop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_aluop   (out_aluop),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          wen;
        logic          use_imm;
        logic [DW-1:0] imm;
        logic [2:0]    aluop;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic wen,
                          input logic use_imm, input logic [DW-1:0] imm,
                          input logic [2:0] aluop);
        in_valid   = 1'b1;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_wen     = wen;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_aluop   = aluop;
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en   = 1'b0;
        $display("wb   r%0d <= %h", a, d);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        in_use_imm = 1'b0;
        in_imm    = '0;
        in_aluop  = '0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;

        vecs[0] = '{5'd5,  5'd0,  5'd0, 1'b0, 1'b0, 32'h0,        3'b010, 32'h12345678, 32'h0};
        vecs[1] = '{5'd1,  5'd2,  5'd0, 1'b0, 1'b0, 32'h0,        3'b000, 32'h11111111, 32'h00000022};
        vecs[2] = '{5'd7,  5'd31, 5'd0, 1'b0, 1'b0, 32'h0,        3'b001, 32'hDEADBEEF, 32'hFFFFFFFF};
        vecs[3] = '{5'd0,  5'd5,  5'd0, 1'b0, 1'b0, 32'h0,        3'b110, 32'h0,        32'h12345678};
        vecs[4] = '{5'd2,  5'd7,  5'd0, 1'b0, 1'b1, 32'hFFFFFFF0, 3'b111, 32'h00000022, 32'hFFFFFFF0};
        vecs[5] = '{5'd31, 5'd7,  5'd0, 1'b1, 1'b0, 32'h0,        3'b010, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[6] = '{5'd3,  5'd4,  5'd9, 1'b0, 1'b0, 32'h0,        3'b001, 32'h0,        32'h0};

        // Reset state
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_stall", stall_count, 32'd0);
        chk("reset_out_A", out_A, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        step();

        wb_write(5'd1, 32'h11111111);
        wb_write(5'd2, 32'h00000022);
        wb_write(5'd5, 32'h12345678);
        wb_write(5'd7, 32'hDEADBEEF);
        wb_write(5'd31, 32'hFFFFFFFF);

        // Table: back-to-back single ops, each checked one cycle later
        for (int i = 0; i < 7; i++) begin
            set_op(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wen,
                   vecs[i].use_imm, vecs[i].imm, vecs[i].aluop);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            $display("vec%0d rs=%0d rt=%0d A=%h B=%h op=%b", i, vecs[i].rs, vecs[i].rt, out_A, out_B, out_aluop);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_A", i), out_A, vecs[i].exp_a);
            chk($sformatf("vec%0d_B", i), out_B, vecs[i].exp_b);
            chk($sformatf("vec%0d_aluop", i), 32'(out_aluop), 32'(vecs[i].aluop));
            chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_wen", i), 32'(out_wen), 32'(vecs[i].wen));
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("no_stall_yet", stall_count, 32'd0);

        // RAW stall on r3, released by same-cycle writeback forwarding
        set_op(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0, 3'b010);
        step();
        set_op(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'b010);
        #1;
        chk("raw_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("raw_stall_count", stall_count, 32'd2);
        chk("raw_in_ready_held", 32'(in_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
        #1;
        chk("raw_byp_ready", 32'(in_ready), 32'd1);
        step();
        wb_en = 1'b0;
        $display("raw  bypass A=%h stall=%0d", out_A, stall_count);
        chk("raw_byp_A", out_A, 32'd7);
        chk("raw_byp_valid", 32'(out_valid), 32'd1);
        chk("raw_stall_final", stall_count, 32'd2);
        // r3 no longer busy; value now comes from the register file
        #1;
        chk("raw_after_ready", 32'(in_ready), 32'd1);
        step();
        chk("raw_after_A", out_A, 32'd7);

        // Backpressure: output held, new op waits, then loads
        set_op(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'b000);
        step();
        out_ready = 1'b0;
        set_op(5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, 3'b001);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_A", out_A, 32'h11111111);
        chk("bp_hold_aluop", 32'(out_aluop), 32'b000);
        chk("bp_no_stall", stall_count, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        $display("bp   release A=%h B=%h", out_A, out_B);
        chk("bp_new_A", out_A, 32'h00000022);
        chk("bp_new_B", out_B, 32'h12345678);
        in_valid = 1'b0;
        step();

        // Immediate bypasses a busy rt; r0 ignores writes
        set_op(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 3'b010);
        step();
        set_op(5'd1, 5'd6, 5'd0, 1'b0, 1'b1, 32'hFFFFFFF0, 3'b010);
        #1;
        chk("imm_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("imm_B", out_B, 32'hFFFFFFF0);
        chk("imm_A", out_A, 32'h11111111);
        wb_write(5'd6, 32'h66);
        wb_write(5'd0, 32'hABCD);
        set_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'b000);
        step();
        in_valid = 1'b0;
        $display("r0   read A=%h B=%h", out_A, out_B);
        chk("r0_A", out_A, 32'd0);
        chk("r0_B", out_B, 32'd0);

        // WAW stall on r4, then asynchronous reset mid-stall
        set_op(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 3'b010);
        step();
        set_op(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 3'b010);
        #1;
        chk("waw_ready", 32'(in_ready), 32'd0);
        step();
        step();
        step();
        chk("waw_stall", stall_count, 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        $display("rst  mid-stall valid=%0d stall=%0d", out_valid, stall_count);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_busy_clear", 32'(in_ready), 32'd1);
        #1;
        resetn = 1'b1;
        in_valid = 1'b0;
        step();
        set_op(5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 3'b000);
        step();
        in_valid = 1'b0;
        chk("rst_regs_A", out_A, 32'd0);
        chk("rst_regs_B", out_B, 32'd0);

        // 256 back-to-back hazard-free ops
        for (int k = 1; k < 8; k++) wb_write(AW'(k), 32'(k) * 32'h100);
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                set_op(AW'(i % 8), 5'd0, AW'(i % 32), 1'b0, 1'b1, 32'(i), 3'b010);
                if (in_ready !== 1'b1) chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_A", i - 1), out_A, 32'((i - 1) % 8) * 32'h100);
                chk($sformatf("stream%0d_B", i - 1), out_B, 32'(i - 1));
            end
            step();
        end
        $display("stream 256 ops done stall=%0d", stall_count);
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_no_stall", stall_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_operand_fetch
